cbuf_delay_ctrl: RTL and testbench

CBUF_DELAY_CTRL -- requirements
Module: cbuf_delay_ctrl

---
 rtl/cbuf_pkg.sv | 14 +
 rtl/cbuf_dpram.sv | 27 ++
 rtl/cbuf_delay_ctrl.sv | 111 +++++++++++
 tb/tb_cbuf_delay_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/cbuf_pkg.sv
// Shared definitions for the circular-buffer delay line: FSM state type and encodings.
package cbuf_pkg;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_FILL_ENC = 2'd1;
    localparam logic [1:0] ST_RUN_ENC  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_FILL = ST_FILL_ENC,
        ST_RUN  = ST_RUN_ENC
    } cbuf_state_e;

endpackage

// File: rtl/cbuf_dpram.sv
// Simple dual-port buffer RAM: one synchronous write port, one synchronous read port.
module cbuf_dpram #(
    parameter int AW = 4,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          re,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    // Read data holds between reads so the controller sees a stable word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/cbuf_delay_ctrl.sv
// Programmable sample delay line: delays the accepted-sample stream by D samples
// using a circular buffer, with IDLE/FILL/RUN sequencing and restart on cfg_load.
//
//   state | meaning
//   IDLE  | no delay configured since reset; ce ignored
//   FILL  | buffer priming, fewer than D samples stored
//   RUN   | D samples stored, each ce produces a delayed sample next cycle
module cbuf_delay_ctrl
    import cbuf_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_load,
    input  logic [AW-1:0] cfg_delay,
    output logic          cfg_err,
    input  logic          ce,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    output logic [1:0]    state,
    output logic [AW-1:0] fill
);

    localparam logic [AW-1:0] ONE = AW'(1);

    cbuf_state_e   st;
    logic [AW-1:0] dly;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] fill_q;
    logic [AW-1:0] rd_addr;
    logic          vld_q;
    logic [DW-1:0] hold_q;
    logic [DW-1:0] rd_data;
    logic          cfg_ok;
    logic          active;
    logic          accept;

    assign cfg_ok  = cfg_load && (cfg_delay != '0);
    assign active  = (st == ST_FILL) || (st == ST_RUN);
    // A restart takes priority over a coincident sample, which is dropped.
    assign accept  = active && ce && !cfg_ok;
    assign rd_addr = wr_ptr - dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= ST_IDLE;
            dly     <= ONE;
            wr_ptr  <= '0;
            fill_q  <= '0;
            vld_q   <= 1'b0;
            hold_q  <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_load && (cfg_delay == '0);
            vld_q   <= accept && (st == ST_RUN);
            if (vld_q) begin
                hold_q <= rd_data;
            end
            if (cfg_ok) begin
                dly    <= cfg_delay;
                wr_ptr <= '0;
                fill_q <= '0;
                st     <= ST_FILL;
            end else begin
                case (st)
                    ST_FILL: begin
                        if (ce) begin
                            wr_ptr <= wr_ptr + ONE;
                            if (fill_q == dly - ONE) begin
                                fill_q <= dly;
                                st     <= ST_RUN;
                            end else begin
                                fill_q <= fill_q + ONE;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (ce) begin
                            wr_ptr <= wr_ptr + ONE;
                        end
                    end
                    default: st <= ST_IDLE;
                endcase
            end
        end
    end

    cbuf_dpram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk     (clk),
        .we      (accept),
        .wr_addr (wr_ptr),
        .wr_data (din),
        .re      (accept),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // The RAM output is only trusted in the cycle a RUN read lands; otherwise the
    // last valid sample is replayed from hold_q.
    assign dout     = vld_q ? rd_data : hold_q;
    assign dout_vld = vld_q;
    assign state    = st;
    assign fill     = fill_q;

endmodule

// File: tb/tb_cbuf_delay_ctrl.sv
// Directed bench for cbuf_delay_ctrl: vector table plus reset and wrap sequences.
module tb_cbuf_delay_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_load;
    logic [3:0] cfg_delay;
    logic       cfg_err;
    logic       ce;
    logic [3:0] din;
    logic [3:0] dout;
    logic       dout_vld;
    logic [1:0] state;
    logic [3:0] fill;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cbuf_delay_ctrl #(.AW(4), .DW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_load  (cfg_load),
        .cfg_delay (cfg_delay),
        .cfg_err   (cfg_err),
        .ce        (ce),
        .din       (din),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .state     (state),
        .fill      (fill)
    );

    typedef struct {
        logic       ld;
        logic [3:0] dl;
        logic       c;
        logic [3:0] d;
        logic       e_vld;
        logic [3:0] e_dout;
        logic [1:0] e_state;
        logic [3:0] e_fill;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ld, input logic [3:0] dl, input logic c,
                                input logic [3:0] d, input logic e_vld, input logic [3:0] e_dout,
                                input logic [1:0] e_state, input logic [3:0] e_fill,
                                input logic e_err);
        vec_t v;
        v.ld = ld; v.dl = dl; v.c = c; v.d = d;
        v.e_vld = e_vld; v.e_dout = e_dout; v.e_state = e_state;
        v.e_fill = e_fill; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic apply(input logic ld, input logic [3:0] dl, input logic c, input logic [3:0] d);
        cfg_load  = ld;
        cfg_delay = dl;
        ce        = c;
        din       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic e_vld, input logic [3:0] e_dout,
                           input logic [1:0] e_state, input logic [3:0] e_fill, input logic e_err);
        chk({tag, "_vld"},   {7'd0, dout_vld}, {7'd0, e_vld});
        chk({tag, "_dout"},  {4'd0, dout},     {4'd0, e_dout});
        chk({tag, "_state"}, {6'd0, state},    {6'd0, e_state});
        chk({tag, "_fill"},  {4'd0, fill},     {4'd0, e_fill});
        chk({tag, "_err"},   {7'd0, cfg_err},  {7'd0, e_err});
    endtask

    logic [3:0] hist [40];

    initial begin
        rst_n = 1'b0; cfg_load = 1'b0; cfg_delay = 4'd0; ce = 1'b0; din = 4'd0;

        // ld dl ce din | vld dout state fill err
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 1, 5, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 6, 0, 0,  0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1,  0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 2,  0, 0, 1, 2, 0));
        vecs.push_back(mk(0, 0, 1, 3,  0, 0, 1, 3, 0));
        vecs.push_back(mk(0, 0, 1, 4,  0, 0, 1, 4, 0));
        vecs.push_back(mk(0, 0, 1, 5,  0, 0, 1, 5, 0));
        vecs.push_back(mk(0, 0, 1, 6,  0, 0, 2, 6, 0));
        vecs.push_back(mk(0, 0, 1, 7,  1, 1, 2, 6, 0));
        vecs.push_back(mk(0, 0, 1, 8,  1, 2, 2, 6, 0));
        vecs.push_back(mk(0, 0, 1, 9,  1, 3, 2, 6, 0));
        vecs.push_back(mk(0, 0, 1, 10, 1, 4, 2, 6, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 4, 2, 6, 0));
        vecs.push_back(mk(1, 0, 1, 11, 1, 5, 2, 6, 1));
        vecs.push_back(mk(0, 0, 1, 12, 1, 6, 2, 6, 0));
        vecs.push_back(mk(1, 2, 1, 13, 0, 6, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 14, 0, 6, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 15, 0, 6, 2, 2, 0));
        vecs.push_back(mk(0, 0, 1, 0,  1, 14, 2, 2, 0));
        vecs.push_back(mk(0, 0, 1, 1,  1, 15, 2, 2, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 15, 2, 2, 0));
        vecs.push_back(mk(1, 3, 0, 0,  0, 15, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 2,  0, 15, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 9,  0, 15, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 3,  0, 15, 1, 2, 0));
        vecs.push_back(mk(0, 0, 1, 4,  0, 15, 2, 3, 0));
        vecs.push_back(mk(0, 0, 0, 9,  0, 15, 2, 3, 0));
        vecs.push_back(mk(0, 0, 1, 5,  1, 2, 2, 3, 0));
        vecs.push_back(mk(0, 0, 1, 6,  1, 3, 2, 3, 0));
        vecs.push_back(mk(0, 0, 0, 9,  0, 3, 2, 3, 0));
        vecs.push_back(mk(0, 0, 1, 7,  1, 4, 2, 3, 0));

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].ld, vecs[i].dl, vecs[i].c, vecs[i].d);
            chk_all($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_dout,
                    vecs[i].e_state, vecs[i].e_fill, vecs[i].e_err);
        end

        // Asynchronous reset in the middle of RUN while dout_vld is high.
        #3;
        cfg_load = 1'b0; ce = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_all("midrun_rst", 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 1, 4'(i + 3));
            chk_all($sformatf("post_rst%0d", i), 0, 0, 0, 0, 0);
        end

        // Maximum delay across several pointer wraps.
        apply(1, 15, 0, 0);
        chk_all("d15_load", 0, 0, 1, 0, 0);
        for (int k = 1; k <= 40; k++) begin
            hist[k-1] = 4'($urandom_range(0, 15));
            apply(0, 0, 1, hist[k-1]);
            chk($sformatf("d15_vld%0d", k), {7'd0, dout_vld}, (k >= 16) ? 8'd1 : 8'd0);
            chk($sformatf("d15_state%0d", k), {6'd0, state}, (k >= 15) ? 8'd2 : 8'd1);
            chk($sformatf("d15_fill%0d", k), {4'd0, fill}, (k < 15) ? 8'(k) : 8'd15);
            if (k >= 16) begin
                chk($sformatf("d15_dout%0d", k), {4'd0, dout}, {4'd0, hist[k-16]});
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
